// File: rtl/status_msg_pkg.sv
// Shared types, constants and banner text lookup for status_msg_sequencer.
package status_msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MSG_NONE = 2'd0;
  localparam logic [1:0] MSG_GAIN = 2'd1;
  localparam logic [1:0] MSG_LOST = 2'd2;
  localparam logic [1:0] MSG_OVER = 2'd3;

  localparam logic [6:0] ASCII_NUL   = 7'h00;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

  localparam int unsigned MSG_TXT_LEN = 10;

  localparam logic [8*MSG_TXT_LEN-1:0] TXT_GAIN  = "LIFE +1   ";
  localparam logic [8*MSG_TXT_LEN-1:0] TXT_LOST  = "LIFE -1   ";
  localparam logic [8*MSG_TXT_LEN-1:0] TXT_OVER  = "GAME OVER ";
  localparam logic [8*MSG_TXT_LEN-1:0] TXT_BLANK = "          ";

  // Character code for slot idx of message id; slots past the text are spaces.
  function automatic logic [6:0] msg_char(input logic [1:0] id, input logic [3:0] idx);
    logic [8*MSG_TXT_LEN-1:0] txt;
    case (id)
      MSG_GAIN: txt = TXT_GAIN;
      MSG_LOST: txt = TXT_LOST;
      MSG_OVER: txt = TXT_OVER;
      default:  txt = TXT_BLANK;
    endcase
    if (id == MSG_NONE) return ASCII_NUL;
    if (idx >= 4'(MSG_TXT_LEN)) return ASCII_SPACE;
    return txt[8*(MSG_TXT_LEN-1-int'(idx)) +: 7];
  endfunction

endpackage

// File: rtl/status_msg_sequencer_timer.sv
// Frame counter with reload; term_c flags the tick that wraps it at TERM.
module msg_frame_timer #(
  parameter int unsigned TERM = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic tick,
  output logic term_c
);

  localparam int unsigned CW = (TERM > 1) ? $clog2(TERM) : 1;

  logic [CW-1:0] count;

  assign term_c = tick && (count == CW'(TERM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (reload) begin
      count <= '0;
    end else if (tick) begin
      count <= term_c ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/status_msg_sequencer.sv
// Status banner sequencer: event arbitration, frame timing and character code per pixel.
// Optional blinking of the banner is enabled by defining MSG_BLINK_EN.
module status_msg_sequencer
  import status_msg_pkg::*;
#(
  parameter int unsigned UP          = 300,
  parameter int unsigned LEFT        = 280,
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned CHAR_H      = 16,
  parameter int unsigned MSG_LEN     = 10,
  parameter int unsigned SHOW_FRAMES = 120,
  parameter int unsigned BLINK_HALF  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        ev_game_over,
  input  logic        ev_life_lost,
  input  logic        ev_life_gain,
  input  logic        clear,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic [2:0]  sel_text,
  output logic [3:0]  regis,
  output logic        char_valid,
  output logic [1:0]  msg_id,
  output logic        busy
);

  localparam int unsigned CSHIFT = $clog2(CHAR_W);

  state_t      state, state_next;
  logic [1:0]  id_next;
  logic        restart;
  logic        show_reload;
  logic        show_term;
  logic        visible;
  logic        in_win;
  logic [10:0] dx;
  logic [3:0]  slot;
  logic [6:0]  glyph;
  logic [6:0]  code_c;
  logic        valid_c;

  // Accepted event while showing: restarts the timeout (or escalates to HOLD).
  assign restart = (state == ST_SHOW) && !clear &&
                   (ev_game_over || ev_life_lost || (ev_life_gain && msg_id == MSG_GAIN));
  assign show_reload = (state != ST_SHOW) || restart;

  msg_frame_timer #(.TERM(SHOW_FRAMES)) u_show_timer (
    .clk    (clk),
    .reset  (reset),
    .reload (show_reload),
    .tick   (frame_tick),
    .term_c (show_term)
  );

  always_comb begin
    state_next = state;
    id_next    = msg_id;
    if (clear) begin
      state_next = ST_IDLE;
      id_next    = MSG_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev_game_over) begin
            state_next = ST_HOLD;
            id_next    = MSG_OVER;
          end else if (ev_life_lost) begin
            state_next = ST_SHOW;
            id_next    = MSG_LOST;
          end else if (ev_life_gain) begin
            state_next = ST_SHOW;
            id_next    = MSG_GAIN;
          end
        end
        ST_SHOW: begin
          if (ev_game_over) begin
            state_next = ST_HOLD;
            id_next    = MSG_OVER;
          end else if (ev_life_lost) begin
            id_next = MSG_LOST;
          end else if (ev_life_gain && msg_id == MSG_GAIN) begin
            id_next = MSG_GAIN;
          end else if (show_term) begin
            state_next = ST_IDLE;
            id_next    = MSG_NONE;
          end
        end
        ST_HOLD: begin
          state_next = ST_HOLD;
        end
        default: begin
          state_next = ST_IDLE;
          id_next    = MSG_NONE;
        end
      endcase
    end
  end

`ifdef MSG_BLINK_EN
  logic blink_reload;
  logic blink_term;

  // Any state change restarts the blink phase in the visible half.
  assign blink_reload = (state == ST_IDLE) || (state_next != state);

  msg_frame_timer #(.TERM(BLINK_HALF)) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .reload (blink_reload),
    .tick   (frame_tick),
    .term_c (blink_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      visible <= 1'b1;
    end else if (blink_reload) begin
      visible <= 1'b1;
    end else if (blink_term) begin
      visible <= ~visible;
    end
  end
`else
  assign visible = 1'b1;
`endif

  // Banner window and character slot under the current pixel.
  assign in_win = (pix_y >= 11'(UP))   && (pix_y < 11'(UP + CHAR_H)) &&
                  (pix_x >= 11'(LEFT)) && (pix_x < 11'(LEFT + MSG_LEN * CHAR_W));
  assign dx      = pix_x - 11'(LEFT);
  assign slot    = 4'(dx >> CSHIFT);
  assign glyph   = msg_char(msg_id, slot);
  assign code_c  = (in_win && state != ST_IDLE) ? glyph : ASCII_NUL;
  assign valid_c = in_win && (state != ST_IDLE) && (glyph != ASCII_SPACE) && visible;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      msg_id     <= MSG_NONE;
      busy       <= 1'b0;
      sel_text   <= 3'd0;
      regis      <= 4'd0;
      char_valid <= 1'b0;
    end else begin
      state      <= state_next;
      msg_id     <= id_next;
      busy       <= (state_next != ST_IDLE);
      sel_text   <= code_c[6:4];
      regis      <= code_c[3:0];
      char_valid <= valid_c;
    end
  end

endmodule

// File: tb/tb_status_msg_sequencer.sv
// Self-checking bench for status_msg_sequencer: pixel vector tables plus event/timing sequences.
module tb_status_msg_sequencer;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [6:0]  code;
    logic        valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        ev_game_over;
  logic        ev_life_lost;
  logic        ev_life_gain;
  logic        clear;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [2:0]  sel_text;
  logic [3:0]  regis;
  logic        char_valid;
  logic [1:0]  msg_id;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  vec_t gain_vec[14];
  vec_t over_vec[5];

  status_msg_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .ev_game_over (ev_game_over),
    .ev_life_lost (ev_life_lost),
    .ev_life_gain (ev_life_gain),
    .clear        (clear),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .sel_text     (sel_text),
    .regis        (regis),
    .char_valid   (char_valid),
    .msg_id       (msg_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel, queue its expectation, compare after the 1-cycle latency.
  task automatic px(input logic [10:0] x, input logic [10:0] y, input logic [6:0] code, input logic v);
    logic [7:0] e;
    pix_x = x;
    pix_y = y;
    exp_q.push_back({code, v});
    step();
    e = exp_q.pop_front();
    check("code", 32'({sel_text, regis}), 32'(e[7:1]));
    check("char_valid", 32'(char_valid), 32'(e[0]));
  endtask

  task automatic pulse(input logic go, input logic lost, input logic gain, input logic clr);
    ev_game_over = go;
    ev_life_lost = lost;
    ev_life_gain = gain;
    clear        = clr;
    step();
    ev_game_over = 1'b0;
    ev_life_lost = 1'b0;
    ev_life_gain = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic state_is(input string name, input logic b, input logic [1:0] id);
    check({name, "_busy"}, 32'(busy), 32'(b));
    check({name, "_msg_id"}, 32'(msg_id), 32'(id));
  endtask

  initial begin
    gain_vec[0]  = '{11'd280, 11'd305, 7'h4C, 1'b1};
    gain_vec[1]  = '{11'd288, 11'd305, 7'h49, 1'b1};
    gain_vec[2]  = '{11'd296, 11'd305, 7'h46, 1'b1};
    gain_vec[3]  = '{11'd311, 11'd305, 7'h45, 1'b1};
    gain_vec[4]  = '{11'd312, 11'd305, 7'h20, 1'b0};
    gain_vec[5]  = '{11'd320, 11'd305, 7'h2B, 1'b1};
    gain_vec[6]  = '{11'd328, 11'd305, 7'h31, 1'b1};
    gain_vec[7]  = '{11'd336, 11'd305, 7'h20, 1'b0};
    gain_vec[8]  = '{11'd359, 11'd305, 7'h20, 1'b0};
    gain_vec[9]  = '{11'd360, 11'd305, 7'h00, 1'b0};
    gain_vec[10] = '{11'd279, 11'd305, 7'h00, 1'b0};
    gain_vec[11] = '{11'd280, 11'd299, 7'h00, 1'b0};
    gain_vec[12] = '{11'd280, 11'd315, 7'h4C, 1'b1};
    gain_vec[13] = '{11'd280, 11'd316, 7'h00, 1'b0};
    over_vec[0]  = '{11'd280, 11'd300, 7'h47, 1'b1};
    over_vec[1]  = '{11'd304, 11'd300, 7'h45, 1'b1};
    over_vec[2]  = '{11'd312, 11'd310, 7'h20, 1'b0};
    over_vec[3]  = '{11'd344, 11'd310, 7'h52, 1'b1};
    over_vec[4]  = '{11'd5,   11'd5,   7'h00, 1'b0};

    reset = 1'b1;
    frame_tick = 1'b0;
    ev_game_over = 1'b0;
    ev_life_lost = 1'b0;
    ev_life_gain = 1'b0;
    clear = 1'b0;
    pix_x = 11'd280;
    pix_y = 11'd300;
    repeat (3) step();
    state_is("reset", 1'b0, 2'd0);
    check("reset_code", 32'({sel_text, regis}), 32'd0);
    check("reset_valid", 32'(char_valid), 32'd0);
    reset = 1'b0;

    // Idle scan across the whole banner row.
    for (int x = 280; x < 360; x++) px(11'(x), 11'd300, 7'h00, 1'b0);

    // Life gain message contents.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    state_is("gain", 1'b1, 2'd1);
    foreach (gain_vec[i]) px(gain_vec[i].x, gain_vec[i].y, gain_vec[i].code, gain_vec[i].valid);

    // Timeout: 120 ticks (a few pixel cycles above did not tick).
    ticks(119);
    state_is("tick119", 1'b1, 2'd1);
    ticks(1);
    state_is("tick120", 1'b0, 2'd0);

    // Re-trigger at tick 100 extends to 100+120.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(100);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(119);
    state_is("ext219", 1'b1, 2'd1);
    ticks(1);
    state_is("ext220", 1'b0, 2'd0);

    // Re-trigger on the terminal tick wins; that tick is not counted.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(119);
    ev_life_gain = 1'b1;
    ticks(1);
    ev_life_gain = 1'b0;
    state_is("term_retrig", 1'b1, 2'd1);
    ticks(119);
    state_is("term_retrig119", 1'b1, 2'd1);
    ticks(1);
    state_is("term_retrig120", 1'b0, 2'd0);

    // Simultaneous gain + game over -> HOLD; HOLD ignores events and time.
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    state_is("over", 1'b1, 2'd3);
    foreach (over_vec[i]) px(over_vec[i].x, over_vec[i].y, over_vec[i].code, over_vec[i].valid);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    state_is("hold_lost", 1'b1, 2'd3);
    ticks(500);
    state_is("hold_500", 1'b1, 2'd3);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    state_is("hold_clear", 1'b0, 2'd0);
    px(11'd280, 11'd300, 7'h00, 1'b0);

    // Lower-priority event dropped; clear beats a simultaneous game over.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    state_is("lost", 1'b1, 2'd2);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    state_is("lost_gain", 1'b1, 2'd2);
    px(11'd328, 11'd305, 7'h31, 1'b1);
    px(11'd320, 11'd305, 7'h2D, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    state_is("clear_go", 1'b0, 2'd0);

    // Upgrade gain -> lost while showing.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    state_is("upgrade", 1'b1, 2'd2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Blink behaviour (or its absence).
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    px(11'd280, 11'd305, 7'h4C, 1'b1);
    ticks(8);
`ifdef MSG_BLINK_EN
    px(11'd280, 11'd305, 7'h4C, 1'b0);
    ticks(8);
    px(11'd280, 11'd305, 7'h4C, 1'b1);
`else
    px(11'd280, 11'd305, 7'h4C, 1'b1);
    ticks(8);
    px(11'd280, 11'd305, 7'h4C, 1'b1);
`endif
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    state_is("final", 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
